// File: rtl/torreta_pkg.sv
// Shared state encodings, debug codes and counter sizing for the turret fire/reload control unit.
// Optional reload watchdog is enabled with TORRETA_TIMEOUT_RECARGA_EN.
package torreta_pkg;

    typedef enum logic [2:0] {
        DESLIGADO       = 3'd0,
        PRONTO          = 3'd1,
        ACIONA          = 3'd2,
        COOLDOWN        = 3'd3,
        PEDE_RECARGA    = 3'd4,
        AGUARDA_RECARGA = 3'd5,
        FALHA           = 3'd6
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'd15;

    // The shared counter only ever reaches (largest phase length - 1).
    function automatic int largura_contador(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [3:0] codigo_db(input estado_t e);
        case (e)
            DESLIGADO:       return 4'd0;
            PRONTO:          return 4'd1;
            ACIONA:          return 4'd2;
            COOLDOWN:        return 4'd3;
            PEDE_RECARGA:    return 4'd4;
            AGUARDA_RECARGA: return 4'd5;
            FALHA:           return 4'd6;
            default:         return DB_INVALIDO;
        endcase
    endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Phase-length up-counter with synchronous clear, enable and terminal compare.
// fim is combinational from the count; clear has priority over enable.
module contador_ciclos #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         habilita,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         cnt <= '0;
        else if (limpa)    cnt <= '0;
        else if (habilita) cnt <= cnt + W'(1);
    end

    assign fim = (cnt == limite);

endmodule

// File: rtl/torreta_disparo_uc.sv
// Turret fire/reload sequencer: Moore FSM, outputs decoded from the state register, municao registered.
// Reload handshake is a one-cycle iniciar_recarga pulse answered by fim_recarga; watchdog under TORRETA_TIMEOUT_RECARGA_EN.
module torreta_disparo_uc
    import torreta_pkg::*;
#(
    parameter int MUNICAO_MAX     = 6,
    parameter int GATILHO_CICLOS  = 25000000,
    parameter int COOLDOWN_CICLOS = 10000000,
    parameter int TIMEOUT_CICLOS  = 150000000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               ligar,
    input  logic                               disparar,
    input  logic                               recarregar,
    input  logic                               fim_recarga,
    output logic                               iniciar_recarga,
    output logic                               gatilho,
    output logic [$clog2(MUNICAO_MAX+1)-1:0]   municao,
    output logic                               vazio,
    output logic                               pronto,
    output logic                               falha,
    output logic [3:0]                         db_estado
);

    localparam int CW = largura_contador(GATILHO_CICLOS, COOLDOWN_CICLOS, TIMEOUT_CICLOS);
    localparam int MW = $clog2(MUNICAO_MAX + 1);
    localparam logic [CW-1:0] LIM_GATILHO  = CW'(GATILHO_CICLOS - 1);
    localparam logic [CW-1:0] LIM_COOLDOWN = CW'(COOLDOWN_CICLOS - 1);
    localparam logic [CW-1:0] LIM_TIMEOUT  = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [MW-1:0] CHEIO        = MW'(MUNICAO_MAX);

    estado_t       estado, prox;
    logic          fim_cnt, cnt_hab;
    logic [CW-1:0] cnt_lim;
    logic          sem_municao;

    assign sem_municao = (municao == '0);

    always_comb begin
        prox = estado;
        case (estado)
            DESLIGADO:
                if (ligar) prox = sem_municao ? PEDE_RECARGA : PRONTO;
            PRONTO:
                if (!ligar)                               prox = DESLIGADO;
                else if (sem_municao)                     prox = PEDE_RECARGA;
                else if (recarregar && (municao < CHEIO)) prox = PEDE_RECARGA;
                else if (disparar)                        prox = ACIONA;
            ACIONA:
                if (fim_cnt) prox = COOLDOWN;
            COOLDOWN:
                if (fim_cnt) begin
                    if (!ligar)           prox = DESLIGADO;
                    else if (sem_municao) prox = PEDE_RECARGA;
                    else                  prox = PRONTO;
                end
            PEDE_RECARGA:
                prox = AGUARDA_RECARGA;
            AGUARDA_RECARGA:
                if (fim_recarga) prox = ligar ? PRONTO : DESLIGADO;
`ifdef TORRETA_TIMEOUT_RECARGA_EN
                else if (fim_cnt) prox = FALHA;
`endif
            FALHA:
`ifdef TORRETA_TIMEOUT_RECARGA_EN
                if (!ligar) prox = DESLIGADO;
`else
                prox = DESLIGADO;
`endif
            default:
                prox = DESLIGADO;
        endcase
    end

    // One counter serves every timed phase; the compare value follows the state.
    always_comb begin
        cnt_lim = LIM_GATILHO;
        cnt_hab = 1'b0;
        case (estado)
            ACIONA:          cnt_hab = 1'b1;
            COOLDOWN: begin
                cnt_lim = LIM_COOLDOWN;
                cnt_hab = 1'b1;
            end
            AGUARDA_RECARGA: begin
                cnt_lim = LIM_TIMEOUT;
`ifdef TORRETA_TIMEOUT_RECARGA_EN
                cnt_hab = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    contador_ciclos #(.W(CW)) u_contador (
        .clock    (clock),
        .reset    (reset),
        .limpa    (prox != estado),
        .habilita (cnt_hab),
        .limite   (cnt_lim),
        .fim      (fim_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= DESLIGADO;
            municao <= '0;
        end else begin
            estado <= prox;
            if (estado == AGUARDA_RECARGA && fim_recarga)
                municao <= CHEIO;
            else if (estado == PRONTO && prox == ACIONA)
                municao <= municao - MW'(1);
        end
    end

    assign gatilho         = (estado == ACIONA);
    assign iniciar_recarga = (estado == PEDE_RECARGA);
    assign pronto          = (estado == PRONTO);
    assign vazio           = sem_municao;
    assign db_estado       = codigo_db(estado);
`ifdef TORRETA_TIMEOUT_RECARGA_EN
    assign falha           = (estado == FALHA);
`else
    assign falha           = 1'b0;
`endif

endmodule

// File: tb/tb_torreta_disparo_uc.sv
// Self-checking bench for torreta_disparo_uc: directed vector table, corner sequences and randomized run against a model.
module tb_torreta_disparo_uc;

    localparam int MAX = 3;
    localparam int G   = 4;
    localparam int C   = 2;
    localparam int T   = 20;
    localparam int MW  = $clog2(MAX + 1);

    localparam int F_OFF = 0, F_READY = 1, F_FIRE = 2, F_COOL = 3, F_REQ = 4, F_WAIT = 5, F_FAIL = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          ligar, disparar, recarregar, fim_recarga;
    logic          iniciar_recarga, gatilho, vazio, pronto, falha;
    logic [MW-1:0] municao;
    logic [3:0]    db_estado;

    int n_checks = 0;
    int n_pass   = 0;

    int m_fase, m_rest, m_mun;

    torreta_disparo_uc #(
        .MUNICAO_MAX     (MAX),
        .GATILHO_CICLOS  (G),
        .COOLDOWN_CICLOS (C),
        .TIMEOUT_CICLOS  (T)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ligar           (ligar),
        .disparar        (disparar),
        .recarregar      (recarregar),
        .fim_recarga     (fim_recarga),
        .iniciar_recarga (iniciar_recarga),
        .gatilho         (gatilho),
        .municao         (municao),
        .vazio           (vazio),
        .pronto          (pronto),
        .falha           (falha),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic l, d, r, f;
        int   mun;
        logic gat, ini, pro;
        int   db;
    } vec_t;

    vec_t tab [20];

    task automatic setv(input int i, input logic l, d, r, f, input int mun,
                        input logic gat, ini, pro, input int db);
        tab[i].l = l; tab[i].d = d; tab[i].r = r; tab[i].f = f;
        tab[i].mun = mun; tab[i].gat = gat; tab[i].ini = ini; tab[i].pro = pro; tab[i].db = db;
    endtask

    function automatic logic [15:0] dut_vec();
        return {5'b0, iniciar_recarga, gatilho, pronto, falha, vazio, municao, db_estado};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [MW-1:0] mm;
        logic [3:0]    fc;
        mm = MW'(m_mun);
        fc = 4'(m_fase);
        return {5'b0, m_fase == F_REQ, m_fase == F_FIRE, m_fase == F_READY, m_fase == F_FAIL,
                m_mun == 0, mm, fc};
    endfunction

    task automatic chk(input string nome, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nome, act, exp);
    endtask

    task automatic model_reset();
        m_fase = F_OFF;
        m_rest = 0;
        m_mun  = 0;
    endtask

    // Phase model: timed phases hold a remaining-cycle budget that counts down.
    task automatic model_step();
        case (m_fase)
            F_OFF:   if (ligar) m_fase = (m_mun == 0) ? F_REQ : F_READY;
            F_READY: begin
                if (!ligar)                          m_fase = F_OFF;
                else if (m_mun == 0)                 m_fase = F_REQ;
                else if (recarregar && m_mun < MAX)  m_fase = F_REQ;
                else if (disparar) begin
                    m_mun  = m_mun - 1;
                    m_fase = F_FIRE;
                    m_rest = G;
                end
            end
            F_FIRE: begin
                m_rest--;
                if (m_rest == 0) begin m_fase = F_COOL; m_rest = C; end
            end
            F_COOL: begin
                m_rest--;
                if (m_rest == 0) m_fase = !ligar ? F_OFF : (m_mun == 0 ? F_REQ : F_READY);
            end
            F_REQ: begin m_fase = F_WAIT; m_rest = T; end
            F_WAIT: begin
                if (fim_recarga) begin
                    m_mun  = MAX;
                    m_fase = ligar ? F_READY : F_OFF;
                end else begin
`ifdef TORRETA_TIMEOUT_RECARGA_EN
                    m_rest--;
                    if (m_rest == 0) m_fase = F_FAIL;
`endif
                end
            end
            F_FAIL:  if (!ligar) m_fase = F_OFF;
            default: m_fase = F_OFF;
        endcase
    endtask

    task automatic ciclo(input logic l, d, r, f, input string nome);
        ligar = l; disparar = d; recarregar = r; fim_recarga = f;
        @(posedge clock);
        model_step();
        #1;
        chk(nome, dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ligar = 1'b0; disparar = 1'b0; recarregar = 1'b0; fim_recarga = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int rises [$];
        int n_ini, n_gat, prev_gat;
        logic [15:0] exp;

        //      l  d  r  f  mun gat ini pro db
        setv(0,  1, 0, 0, 0, 0,  0,  1,  0, 4);
        setv(1,  1, 0, 0, 1, 0,  0,  0,  0, 5);
        setv(2,  1, 0, 0, 1, 3,  0,  0,  1, 1);
        setv(3,  1, 1, 0, 0, 2,  1,  0,  0, 2);
        setv(4,  1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(5,  1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(6,  1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(7,  1, 0, 0, 0, 2,  0,  0,  0, 3);
        setv(8,  1, 1, 0, 0, 2,  0,  0,  0, 3);
        setv(9,  1, 0, 0, 0, 2,  0,  0,  1, 1);
        setv(10, 1, 1, 1, 0, 2,  0,  1,  0, 4);
        setv(11, 1, 1, 1, 0, 2,  0,  0,  0, 5);
        setv(12, 1, 0, 0, 1, 3,  0,  0,  1, 1);
        setv(13, 1, 1, 1, 0, 2,  1,  0,  0, 2);
        setv(14, 1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(15, 1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(16, 1, 0, 0, 0, 2,  1,  0,  0, 2);
        setv(17, 1, 0, 0, 0, 2,  0,  0,  0, 3);
        setv(18, 1, 0, 0, 0, 2,  0,  0,  0, 3);
        setv(19, 1, 0, 0, 0, 2,  0,  0,  1, 1);

        do_reset();
        chk("reset_state", dut_vec(), 16'b00000_00001_00_0000);

        for (int i = 0; i < 20; i++) begin
            logic [MW-1:0] em;
            logic [3:0]    ed;
            ligar = tab[i].l; disparar = tab[i].d; recarregar = tab[i].r; fim_recarga = tab[i].f;
            @(posedge clock);
            #1;
            em  = MW'(tab[i].mun);
            ed  = 4'(tab[i].db);
            exp = {5'b0, tab[i].ini, tab[i].gat, tab[i].pro, 1'b0, tab[i].mun == 0, em, ed};
            chk($sformatf("table_row%0d", i), dut_vec(), exp);
        end

        // Auto-fire with disparar held until the magazine empties.
        do_reset();
        ciclo(1, 0, 0, 0, "arm");
        ciclo(1, 0, 0, 0, "arm_wait");
        ciclo(1, 0, 0, 1, "arm_loaded");
        prev_gat = 0;
        n_ini = 0;
        for (int k = 0; k < 30; k++) begin
            ciclo(1, 1, 0, 0, "autofire");
            if (gatilho && prev_gat == 0) rises.push_back(k);
            if (iniciar_recarga) n_ini++;
            prev_gat = int'(gatilho);
        end
        chk("autofire_shots", 16'(rises.size()), 16'd3);
        if (rises.size() == 3) begin
            chk("autofire_period1", 16'(rises[1] - rises[0]), 16'(G + C + 1));
            chk("autofire_period2", 16'(rises[2] - rises[1]), 16'(G + C + 1));
        end
        chk("autofire_one_reload_req", 16'(n_ini), 16'd1);
        chk("autofire_empty", 16'(vazio), 16'd1);
        ciclo(1, 1, 0, 1, "autofire_reloaded");

        // Dropping ligar during a shot still completes the trigger pulse.
        ciclo(1, 1, 0, 0, "drop_shot");
        n_gat = int'(gatilho);
        for (int k = 0; k < 6; k++) begin
            ciclo(0, 0, 0, 0, "drop_ligar");
            n_gat += int'(gatilho);
        end
        chk("drop_gatilho_cycles", 16'(n_gat), 16'(G));
        chk("drop_final_state", 16'(db_estado), 16'd0);

        // Asynchronous reset while waiting for the reload unit.
        ciclo(1, 0, 0, 0, "rearm");
        ciclo(1, 0, 1, 0, "manual_reload");
        ciclo(1, 0, 0, 0, "manual_wait");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_municao", 16'(municao), 16'd0);
        chk("async_reset_state", 16'(db_estado), 16'd0);
        model_reset();
        ligar = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ciclo(1, 0, 0, 0, "after_reset_forces_reload");

        // Reload with no answer: watchdog when enabled, indefinite wait otherwise.
        ciclo(1, 0, 0, 0, "timeout_wait");
        for (int k = 0; k < T; k++) ciclo(1, 0, 0, 0, "timeout_run");
`ifdef TORRETA_TIMEOUT_RECARGA_EN
        chk("timeout_falha", 16'(falha), 16'd1);
        chk("timeout_db", 16'(db_estado), 16'd6);
        ciclo(1, 1, 1, 1, "falha_holds");
        ciclo(0, 0, 0, 0, "falha_exit");
        chk("falha_cleared", 16'(falha), 16'd0);
`else
        chk("no_timeout_db", 16'(db_estado), 16'd5);
        ciclo(1, 0, 0, 1, "late_reload");
`endif

        // Randomized operation against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            ciclo($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
